// File: rtl/mac_acc_multich_if.sv
// Sample/result bus between the coefficient sequencer and the multi-channel MAC.
// The sequencer drives the master side; the MAC is the slave.
interface mac_acc_multich_if #(
  parameter int Win  = 16,
  parameter int Wc   = 18,
  parameter int Wout = 16,
  parameter int NCH  = 4
) ();
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                   clr;
  logic                   din_valid;
  logic signed [Win-1:0]  din;
  logic signed [Wc-1:0]   coef;
  logic [CHW-1:0]         din_ch;
  logic                   din_last;
  logic signed [Wout-1:0] dout;
  logic [CHW-1:0]         dout_ch;
  logic                   dout_valid;
  logic                   dout_sat;

  modport master (
    output clr, din_valid, din, coef, din_ch, din_last,
    input  dout, dout_ch, dout_valid, dout_sat
  );

  modport slave (
    input  clr, din_valid, din, coef, din_ch, din_last,
    output dout, dout_ch, dout_valid, dout_sat
  );
endinterface

// File: rtl/mac_acc_multich.sv
// NCH independent accumulators sharing one multiplier; a 'last' sample dumps the
// channel sum rounded half-up, scaled by 2^-SHIFT and saturated to Wout bits.
module mac_acc_multich #(
  parameter int Win   = 16,
  parameter int Wc    = 18,
  parameter int Wacc  = 40,
  parameter int Wout  = 16,
  parameter int SHIFT = 17,
  parameter int NCH   = 4
) (
  input logic              clk,
  input logic              rst_n,
  mac_acc_multich_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WP  = Win + Wc;
  localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);
  localparam longint MAXL = (64'sd1 <<< (Wout-1)) - 64'sd1;
  localparam logic signed [Wacc:0] MAXV = (Wacc+1)'(MAXL);
  localparam logic signed [Wacc:0] MINV = (Wacc+1)'(-MAXL - 64'sd1);

  logic signed [WP-1:0]   r_p;
  logic [CHW-1:0]         r_ch;
  logic                   r_last;
  logic                   r_vld;
  logic signed [Wacc-1:0] r_acc [NCH];
  logic signed [Wout-1:0] r_dout;
  logic [CHW-1:0]         r_dout_ch;
  logic                   r_dout_valid;
  logic                   r_dout_sat;

  logic                   w_take;
  logic signed [WP-1:0]   w_prod;
  logic signed [Wacc-1:0] w_p_ext;
  logic signed [Wacc-1:0] w_sum;
  logic signed [Wacc:0]   w_sum_x;
  logic signed [Wacc:0]   w_rnd;
  logic                   w_hi;
  logic                   w_lo;
  logic signed [Wout-1:0] w_dout;

  // Out-of-range channels never reach S2, so r_ch always indexes a real accumulator.
  assign w_take  = bus.din_valid && ({1'b0, bus.din_ch} < NCH_L);
  assign w_prod  = WP'(bus.din) * WP'(bus.coef);
  assign w_p_ext = Wacc'(r_p);
  assign w_sum   = r_acc[r_ch] + w_p_ext;
  assign w_sum_x = {w_sum[Wacc-1], w_sum};

  // One extra bit so adding the half-LSB cannot overflow.
  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [Wacc:0] HALF = {{Wacc{1'b0}}, 1'b1} << (SHIFT-1);
    assign w_rnd = (w_sum_x + HALF) >>> SHIFT;
  end else begin : g_nornd
    assign w_rnd = w_sum_x;
  end

  assign w_hi   = (w_rnd > MAXV);
  assign w_lo   = (w_rnd < MINV);
  assign w_dout = w_hi ? MAXV[Wout-1:0] : (w_lo ? MINV[Wout-1:0] : w_rnd[Wout-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p          <= '0;
      r_ch         <= '0;
      r_last       <= 1'b0;
      r_vld        <= 1'b0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_dout_sat   <= 1'b0;
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
    end else if (bus.clr) begin
      r_vld        <= 1'b0;
      r_dout_valid <= 1'b0;
      for (int i = 0; i < NCH; i++) r_acc[i] <= '0;
    end else begin
      r_vld        <= w_take;
      r_dout_valid <= 1'b0;
      if (w_take) begin
        r_p    <= w_prod;
        r_ch   <= bus.din_ch;
        r_last <= bus.din_last;
      end
      if (r_vld) begin
        if (r_last) begin
          r_acc[r_ch]  <= '0;
          r_dout       <= w_dout;
          r_dout_ch    <= r_ch;
          r_dout_sat   <= w_hi || w_lo;
          r_dout_valid <= 1'b1;
        end else begin
          r_acc[r_ch] <= w_sum;
        end
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_sat   = r_dout_sat;
endmodule
